csr_issue_queue: RTL and testbench

Parametrised CSR issue queue for the out-of-order front end. It accepts CSR instructions from two producers, the issue stage and writeback replay, through a permit-gated mutex merge, and buffers them in a DEPTH-entry FIFO. It forms each head instruction's operand from immediate, bypass or GRF, and hands a registered {instruction, operand} packet to the CSR execute unit over a drive/free handshake. It generalises the fixed 16-entry, single-source CSR FIFO with configurable width, depth, dual-source merge, occupancy reporting and a flush.

---
 rtl/csr_issue_pkg.sv | 20 ++
 rtl/csr_issue_queue_if.sv | 46 ++++
 rtl/csr_issue_ram.sv | 25 ++
 rtl/csr_issue_queue.sv | 118 +++++++++++
 tb/tb_csr_issue_queue.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_issue_pkg.sv
// rtl/csr_issue_pkg.sv - shared types, bypass tag constant and gray helper for the CSR issue queue
package csr_issue_pkg;

    localparam int PKT_INSN_W = 113;
    localparam int PKT_DATA_W = 32;
    localparam int PKT_DEP_W  = 4;

    typedef struct packed {
        logic [PKT_INSN_W-1:0] insn;
        logic [PKT_DATA_W-1:0] operand;
    } csr_packet_t;

    // A dependency tag of all ones means the operand comes from the bypass buffer
    localparam logic [PKT_DEP_W-1:0] DEP_BYPASS = '1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/csr_issue_queue_if.sv
// rtl/csr_issue_queue_if.sv - producer, operand lookup and execute handshake bundle
interface csr_issue_queue_if #(
    parameter int DEPTH  = 16,
    parameter int INSN_W = 113,
    parameter int DATA_W = 32,
    parameter int DEP_W  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     i_flush;
    logic                     i_is_first;
    logic                     i_drive_issue_1;
    logic [INSN_W-1:0]        i_insn_issue;
    logic                     o_free_issue_1;
    logic                     i_drive_wb_1;
    logic [INSN_W-1:0]        i_insn_wb;
    logic                     o_free_wb_1;
    logic [INSN_W-1:0]        o_head_insn;
    logic                     i_rs1_valid_1;
    logic [DATA_W-1:0]        i_imm;
    logic [DEP_W-1:0]         i_dep;
    logic [DATA_W-1:0]        i_operand_bypass;
    logic [DATA_W-1:0]        i_operand_grf;
    logic                     o_drive_exe_1;
    logic [INSN_W+DATA_W-1:0] o_packet;
    logic                     i_free_exe_1;
    logic [CW-1:0]            o_count;
    logic [CW-1:0]            o_count_gray;
    logic                     o_empty;
    logic                     o_full;

    modport master (
        output i_flush, i_is_first, i_drive_issue_1, i_insn_issue, i_drive_wb_1, i_insn_wb,
               i_rs1_valid_1, i_imm, i_dep, i_operand_bypass, i_operand_grf, i_free_exe_1,
        input  o_free_issue_1, o_free_wb_1, o_head_insn, o_drive_exe_1, o_packet,
               o_count, o_count_gray, o_empty, o_full
    );

    modport slave (
        input  i_flush, i_is_first, i_drive_issue_1, i_insn_issue, i_drive_wb_1, i_insn_wb,
               i_rs1_valid_1, i_imm, i_dep, i_operand_bypass, i_operand_grf, i_free_exe_1,
        output o_free_issue_1, o_free_wb_1, o_head_insn, o_drive_exe_1, o_packet,
               o_count, o_count_gray, o_empty, o_full
    );

endinterface

// File: rtl/csr_issue_ram.sv
// rtl/csr_issue_ram.sv - DEPTH x INSN_W storage, synchronous write, combinational read, no reset
module csr_issue_ram #(
    parameter int DEPTH  = 16,
    parameter int INSN_W = 113,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INSN_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INSN_W-1:0] rdata
);

    logic [INSN_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/csr_issue_queue.sv
// rtl/csr_issue_queue.sv - dual-source CSR issue FIFO with registered execute packet
// Optional feature macro: CSR_ISSUE_BYPASS_EN (adds bypass-buffer operand forwarding).
module csr_issue_queue
    import csr_issue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int INSN_W = 113,
    parameter int DATA_W = 32,
    parameter int DEP_W  = 4
) (
    input logic            clk,
    input logic            rstn,
    csr_issue_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]            wr_ptr;
    logic [CW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic                     empty;
    logic                     full;
    logic                     permit_issue;
    logic                     permit_wb;
    logic                     free_issue;
    logic                     free_wb;
    logic                     enq;
    logic                     load;
    logic [INSN_W-1:0]        wdata;
    logic [INSN_W-1:0]        ram_rdata;
    logic [INSN_W-1:0]        head;
    logic [DATA_W-1:0]        operand;
    logic                     use_bypass;
    logic                     drive_exe;
    logic [INSN_W+DATA_W-1:0] packet;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Program order: issue stage owns the slot when the queue is empty or it is next in order
    assign permit_issue = empty | bus.i_is_first;
    assign permit_wb    = ~(empty | bus.i_is_first);

    assign free_issue = bus.i_drive_issue_1 & permit_issue & ~full & ~bus.i_flush;
    assign free_wb    = bus.i_drive_wb_1 & permit_wb & ~full & ~bus.i_flush;
    assign enq        = free_issue | free_wb;
    assign wdata      = free_issue ? bus.i_insn_issue : bus.i_insn_wb;

    assign load = ~empty & (~drive_exe | bus.i_free_exe_1) & ~bus.i_flush;

    csr_issue_ram #(
        .DEPTH  (DEPTH),
        .INSN_W (INSN_W)
    ) u_ram (
        .clk    (clk),
        .we     (enq),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (wdata),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (ram_rdata)
    );

    assign head = empty ? '0 : ram_rdata;

`ifdef CSR_ISSUE_BYPASS_EN
    assign use_bypass = &bus.i_dep;
`else
    logic unused_bypass;
    assign unused_bypass = ^{bus.i_dep, bus.i_operand_bypass};
    assign use_bypass    = 1'b0;
`endif

    always_comb begin
        operand = bus.i_operand_grf;
        if (!bus.i_rs1_valid_1) begin
            operand = bus.i_imm;
        end else if (use_bypass) begin
            operand = bus.i_operand_bypass;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            drive_exe <= 1'b0;
            packet    <= '0;
        end else if (bus.i_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            drive_exe <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr    <= rd_ptr + 1'b1;
                drive_exe <= 1'b1;
                packet    <= {head, operand};
            end else if (bus.i_free_exe_1) begin
                drive_exe <= 1'b0;
            end
        end
    end

    assign bus.o_free_issue_1 = free_issue;
    assign bus.o_free_wb_1    = free_wb;
    assign bus.o_head_insn    = head;
    assign bus.o_drive_exe_1  = drive_exe;
    assign bus.o_packet       = packet;
    assign bus.o_count        = count;
    assign bus.o_count_gray   = CW'(bin2gray(32'(count)));
    assign bus.o_empty        = empty;
    assign bus.o_full         = full;

endmodule

// File: tb/tb_csr_issue_queue.sv
// tb/tb_csr_issue_queue.sv - directed self-checking bench for csr_issue_queue (DEPTH = 4)
module tb_csr_issue_queue;
    import csr_issue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int INSN_W = PKT_INSN_W;
    localparam int DATA_W = PKT_DATA_W;

    logic clk;
    logic rstn;
    int   compared;
    int   mismatched;

    csr_issue_queue_if #(.DEPTH(DEPTH), .INSN_W(INSN_W), .DATA_W(DATA_W)) bus ();

    csr_issue_queue #(
        .DEPTH  (DEPTH),
        .INSN_W (INSN_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic csr_packet_t pkt(input logic [INSN_W-1:0] insn, input logic [DATA_W-1:0] op);
        csr_packet_t p;
        p.insn    = insn;
        p.operand = op;
        return p;
    endfunction

    initial begin
        int sent;
        int rcv;
        int cyc;
        logic [DATA_W-1:0] exp_op;

        compared   = 0;
        mismatched = 0;
        bus.i_flush = 0; bus.i_is_first = 1; bus.i_drive_issue_1 = 0; bus.i_insn_issue = '0;
        bus.i_drive_wb_1 = 0; bus.i_insn_wb = '0; bus.i_rs1_valid_1 = 0; bus.i_imm = 32'h55;
        bus.i_dep = '0; bus.i_operand_bypass = '0; bus.i_operand_grf = '0; bus.i_free_exe_1 = 0;

        rstn = 1'b1;
        #1 rstn = 1'b0;
        #3;
        chk("rst_count", 256'(bus.o_count), 256'(0));
        chk("rst_gray", 256'(bus.o_count_gray), 256'(0));
        chk("rst_empty", 256'(bus.o_empty), 256'(1));
        chk("rst_full", 256'(bus.o_full), 256'(0));
        chk("rst_drive", 256'(bus.o_drive_exe_1), 256'(0));
        chk("rst_packet", 256'(bus.o_packet), 256'(0));
        chk("rst_head", 256'(bus.o_head_insn), 256'(0));
        #18 rstn = 1'b1;
        tick();

        // First enqueue, one-cycle latency to the execute packet
        bus.i_drive_issue_1 = 1; bus.i_insn_issue = 113'h1A3;
        #1 chk("first_free", 256'(bus.o_free_issue_1), 256'(1));
        tick();
        bus.i_drive_issue_1 = 0;
        #1 chk("first_not_yet", 256'(bus.o_drive_exe_1), 256'(0));
        chk("first_head", 256'(bus.o_head_insn), 256'(113'h1A3));
        tick();
        chk("first_drive", 256'(bus.o_drive_exe_1), 256'(1));
        chk("first_packet", 256'(bus.o_packet), 256'(pkt(113'h1A3, 32'h55)));
        bus.i_free_exe_1 = 1;
        tick();
        chk("first_done", 256'(bus.o_drive_exe_1), 256'(0));
        bus.i_free_exe_1 = 0;

        // Permit arbitration with a non-empty queue
        bus.i_drive_issue_1 = 1; bus.i_insn_issue = 113'h0A0;
        tick();
        bus.i_drive_wb_1 = 1; bus.i_insn_wb = 113'h0B0; bus.i_is_first = 0;
        #1 chk("perm_wb_free", 256'(bus.o_free_wb_1), 256'(1));
        chk("perm_wb_issue", 256'(bus.o_free_issue_1), 256'(0));
        bus.i_is_first = 1;
        #1 chk("perm_is_issue", 256'(bus.o_free_issue_1), 256'(1));
        chk("perm_is_wb", 256'(bus.o_free_wb_1), 256'(0));
        bus.i_drive_issue_1 = 0; bus.i_drive_wb_1 = 0;
        tick();
        chk("perm_packet", 256'(bus.o_packet), 256'(pkt(113'h0A0, 32'h55)));
        bus.i_free_exe_1 = 1;
        tick();
        bus.i_free_exe_1 = 0;

        // Fill with execute stalled: one entry sits in the output register, four in the FIFO
        bus.i_imm = 32'h77;
        for (int i = 0; i < 5; i++) begin
            bus.i_drive_issue_1 = 1; bus.i_insn_issue = INSN_W'(32'h100 + i);
            tick();
        end
        bus.i_insn_issue = 113'h105;
        #1 chk("full_flag", 256'(bus.o_full), 256'(1));
        chk("full_count", 256'(bus.o_count), 256'(4));
        chk("full_gray", 256'(bus.o_count_gray), 256'(6));
        chk("full_refuse", 256'(bus.o_free_issue_1), 256'(0));
        bus.i_drive_issue_1 = 0;
        bus.i_free_exe_1 = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("drain_drive", 256'(bus.o_drive_exe_1), 256'(1));
            chk("drain_order", 256'(bus.o_packet), 256'(pkt(INSN_W'(32'h100 + i), 32'h77)));
            tick();
        end
        chk("drain_empty", 256'(bus.o_empty), 256'(1));
        chk("drain_idle", 256'(bus.o_drive_exe_1), 256'(0));
        bus.i_free_exe_1 = 0;

        // Dependency tag all ones: bypass only when the feature is built in
        bus.i_rs1_valid_1 = 1; bus.i_dep = DEP_BYPASS;
        bus.i_operand_bypass = 32'hDEAD; bus.i_operand_grf = 32'hBEEF;
        bus.i_drive_issue_1 = 1; bus.i_insn_issue = 113'h2BC;
        tick();
        bus.i_drive_issue_1 = 0;
        tick();
`ifdef CSR_ISSUE_BYPASS_EN
        exp_op = 32'hDEAD;
`else
        exp_op = 32'hBEEF;
`endif
        chk("bypass_packet", 256'(bus.o_packet), 256'(pkt(113'h2BC, exp_op)));
        bus.i_free_exe_1 = 1;
        tick();
        bus.i_rs1_valid_1 = 0; bus.i_dep = '0;

        // Pointer wrap with random execute stalls
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 2 * DEPTH + 3 && cyc < 400) begin
            bus.i_drive_issue_1 = (sent < 2 * DEPTH + 3);
            bus.i_insn_issue    = INSN_W'(32'h300 + sent);
            bus.i_free_exe_1    = 1'($urandom_range(0, 1));
            #1;
            if (bus.o_drive_exe_1 && bus.i_free_exe_1) begin
                chk("wrap_order", 256'(bus.o_packet), 256'(pkt(INSN_W'(32'h300 + rcv), 32'h77)));
                rcv++;
            end
            if (bus.o_free_issue_1) sent++;
            tick();
            cyc++;
        end
        chk("wrap_received", 256'(rcv), 256'(2 * DEPTH + 3));
        chk("wrap_sent", 256'(sent), 256'(2 * DEPTH + 3));
        chk("wrap_empty", 256'(bus.o_empty), 256'(1));
        bus.i_drive_issue_1 = 0; bus.i_free_exe_1 = 0;
        tick();

        // Flush with three queued entries and a pending output
        for (int i = 0; i < 4; i++) begin
            bus.i_drive_issue_1 = 1; bus.i_insn_issue = INSN_W'(32'h400 + i);
            tick();
        end
        bus.i_drive_issue_1 = 0;
        #1 chk("preflush_count", 256'(bus.o_count), 256'(3));
        chk("preflush_drive", 256'(bus.o_drive_exe_1), 256'(1));
        bus.i_flush = 1;
        tick();
        bus.i_flush = 0;
        chk("flush_count", 256'(bus.o_count), 256'(0));
        chk("flush_drive", 256'(bus.o_drive_exe_1), 256'(0));
        chk("flush_empty", 256'(bus.o_empty), 256'(1));
        chk("flush_head", 256'(bus.o_head_insn), 256'(0));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 2; i++) begin
            bus.i_drive_issue_1 = 1; bus.i_insn_issue = INSN_W'(32'h500 + i);
            tick();
        end
        bus.i_drive_issue_1 = 0;
        #2 rstn = 1'b0;
        #1 chk("arst_drive", 256'(bus.o_drive_exe_1), 256'(0));
        chk("arst_packet", 256'(bus.o_packet), 256'(0));
        chk("arst_count", 256'(bus.o_count), 256'(0));
        chk("arst_empty", 256'(bus.o_empty), 256'(1));
        chk("arst_head", 256'(bus.o_head_insn), 256'(0));
        #1 rstn = 1'b1;
        bus.i_free_exe_1 = 1;
        tick();
        chk("arst_quiet", 256'(bus.o_drive_exe_1), 256'(0));
        bus.i_drive_issue_1 = 1; bus.i_insn_issue = 113'h600;
        tick();
        bus.i_drive_issue_1 = 0;
        tick();
        chk("arst_new_drive", 256'(bus.o_drive_exe_1), 256'(1));
        chk("arst_new_packet", 256'(bus.o_packet), 256'(pkt(113'h600, 32'h77)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
